// File: rtl/i_execute.sv
// MIPS execute stage: ALU control, 32-bit ALU, branch target, destination select,
// and the EX/MEM pipeline register with flush-over-hold priority.
module i_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [1:0]  ID_EX_wb_ctlout,
    input  logic [2:0]  ID_EX_m_ctlout,
    input  logic [3:0]  ID_EX_ex_ctlout,
    input  logic [31:0] ID_EX_npcout,
    input  logic [31:0] ID_EX_rdata1out,
    input  logic [31:0] ID_EX_rdata2out,
    input  logic [31:0] ID_EX_s_extendout,
    input  logic [4:0]  ID_EX_instrout_2016,
    input  logic [4:0]  ID_EX_instrout_1511,
    output logic [1:0]  EX_MEM_wb_ctlout,
    output logic        EX_MEM_branch,
    output logic        EX_MEM_memread,
    output logic        EX_MEM_memwrite,
    output logic        EX_MEM_PCSrc,
    output logic [31:0] EX_MEM_NPC,
    output logic        EX_MEM_zero,
    output logic [31:0] EX_MEM_alu_result,
    output logic [31:0] EX_MEM_rdata2out,
    output logic [4:0]  EX_MEM_five_bit_muxout
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NONE
    } alu_op_e;

    logic        regdst;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        branch;
    alu_op_e     alu_op;
    logic [31:0] operand_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] branch_target;
    logic [4:0]  dest_reg;

    assign regdst = ID_EX_ex_ctlout[3];
    assign aluop  = ID_EX_ex_ctlout[2:1];
    assign alusrc = ID_EX_ex_ctlout[0];
    assign branch = ID_EX_m_ctlout[2];

    always_comb begin
        alu_op = ALU_NONE;
        case (aluop)
            2'b00:   alu_op = ALU_ADD;
            2'b01:   alu_op = ALU_SUB;
            2'b11:   alu_op = ALU_ADD;
            default: begin
                case (ID_EX_s_extendout[5:0])
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
                    default:   alu_op = ALU_NONE;
                endcase
            end
        endcase
    end

    // Unrecognised funct codes produce a zero result rather than an exception.
    always_comb begin
        operand_b  = alusrc ? ID_EX_s_extendout : ID_EX_rdata2out;
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD: alu_result = ID_EX_rdata1out + operand_b;
            ALU_SUB: alu_result = ID_EX_rdata1out - operand_b;
            ALU_AND: alu_result = ID_EX_rdata1out & operand_b;
            ALU_OR:  alu_result = ID_EX_rdata1out | operand_b;
            ALU_SLT: alu_result = {31'h0, $signed(ID_EX_rdata1out) < $signed(operand_b)};
            default: alu_result = 32'h0;
        endcase
    end

    assign alu_zero      = (alu_result == 32'h0);
    assign branch_target = ID_EX_npcout + {ID_EX_s_extendout[29:0], 2'b00};
    assign dest_reg      = regdst ? ID_EX_instrout_1511 : ID_EX_instrout_2016;

    logic [1:0]  wb_q,       wb_d;
    logic        branch_q,   branch_d;
    logic        memread_q,  memread_d;
    logic        memwrite_q, memwrite_d;
    logic        pcsrc_q,    pcsrc_d;
    logic [31:0] npc_q,      npc_d;
    logic        zero_q,     zero_d;
    logic [31:0] result_q,   result_d;
    logic [31:0] rdata2_q,   rdata2_d;
    logic [4:0]  dest_q,     dest_d;

    // Flush outranks hold so a squashed instruction cannot linger while stalled.
    always_comb begin
        wb_d       = wb_q;
        branch_d   = branch_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        pcsrc_d    = pcsrc_q;
        npc_d      = npc_q;
        zero_d     = zero_q;
        result_d   = result_q;
        rdata2_d   = rdata2_q;
        dest_d     = dest_q;
        if (flush) begin
            wb_d       = 2'b00;
            branch_d   = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            pcsrc_d    = 1'b0;
            npc_d      = 32'h0;
            zero_d     = 1'b0;
            result_d   = 32'h0;
            rdata2_d   = 32'h0;
            dest_d     = 5'h0;
        end else if (!hold) begin
            wb_d       = ID_EX_wb_ctlout;
            branch_d   = branch;
            memread_d  = ID_EX_m_ctlout[1];
            memwrite_d = ID_EX_m_ctlout[0];
            pcsrc_d    = branch & alu_zero;
            npc_d      = branch_target;
            zero_d     = alu_zero;
            result_d   = alu_result;
            rdata2_d   = ID_EX_rdata2out;
            dest_d     = dest_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q       <= 2'b00;
            branch_q   <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            pcsrc_q    <= 1'b0;
            npc_q      <= 32'h0;
            zero_q     <= 1'b0;
            result_q   <= 32'h0;
            rdata2_q   <= 32'h0;
            dest_q     <= 5'h0;
        end else begin
            wb_q       <= wb_d;
            branch_q   <= branch_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            pcsrc_q    <= pcsrc_d;
            npc_q      <= npc_d;
            zero_q     <= zero_d;
            result_q   <= result_d;
            rdata2_q   <= rdata2_d;
            dest_q     <= dest_d;
        end
    end

    assign EX_MEM_wb_ctlout       = wb_q;
    assign EX_MEM_branch          = branch_q;
    assign EX_MEM_memread         = memread_q;
    assign EX_MEM_memwrite        = memwrite_q;
    assign EX_MEM_PCSrc           = pcsrc_q;
    assign EX_MEM_NPC             = npc_q;
    assign EX_MEM_zero            = zero_q;
    assign EX_MEM_alu_result      = result_q;
    assign EX_MEM_rdata2out       = rdata2_q;
    assign EX_MEM_five_bit_muxout = dest_q;

endmodule

// File: tb/tb_i_execute.sv
// Self-checking bench for i_execute: directed test-plan steps followed by random
// traffic, all checked against an arithmetic reference model of the EX/MEM register.
module tb_i_execute;

    typedef struct packed {
        logic [1:0]  wb;
        logic        br;
        logic        mr;
        logic        mw;
        logic        pcsrc;
        logic [31:0] npc;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  dest;
    } exOut_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic [1:0]  wbIn;
    logic [2:0]  mIn;
    logic [3:0]  exIn;
    logic [31:0] npcIn;
    logic [31:0] rsIn;
    logic [31:0] rtIn;
    logic [31:0] immIn;
    logic [4:0]  rtIdx;
    logic [4:0]  rdIdx;

    logic [1:0]  wbOut;
    logic        brOut;
    logic        mrOut;
    logic        mwOut;
    logic        pcsrcOut;
    logic [31:0] npcOut;
    logic        zeroOut;
    logic [31:0] aluOut;
    logic [31:0] rd2Out;
    logic [4:0]  destOut;

    exOut_t expQ;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    i_execute dut (
        .clk                    (clk),
        .rst                    (rst),
        .hold                   (hold),
        .flush                  (flush),
        .ID_EX_wb_ctlout        (wbIn),
        .ID_EX_m_ctlout         (mIn),
        .ID_EX_ex_ctlout        (exIn),
        .ID_EX_npcout           (npcIn),
        .ID_EX_rdata1out        (rsIn),
        .ID_EX_rdata2out        (rtIn),
        .ID_EX_s_extendout      (immIn),
        .ID_EX_instrout_2016    (rtIdx),
        .ID_EX_instrout_1511    (rdIdx),
        .EX_MEM_wb_ctlout       (wbOut),
        .EX_MEM_branch          (brOut),
        .EX_MEM_memread         (mrOut),
        .EX_MEM_memwrite        (mwOut),
        .EX_MEM_PCSrc           (pcsrcOut),
        .EX_MEM_NPC             (npcOut),
        .EX_MEM_zero            (zeroOut),
        .EX_MEM_alu_result      (aluOut),
        .EX_MEM_rdata2out       (rd2Out),
        .EX_MEM_five_bit_muxout (destOut)
    );

    // Reference: what the instruction currently on the inputs should produce.
    function automatic exOut_t computeExpected();
        exOut_t e;
        logic [31:0] b;
        logic [31:0] r;
        b = exIn[0] ? immIn : rtIn;
        r = 32'h0;
        if (exIn[2:1] == 2'b01) r = rsIn - b;
        else if (exIn[2:1] != 2'b10) r = rsIn + b;
        else if (immIn[5:0] == 6'd32) r = rsIn + b;
        else if (immIn[5:0] == 6'd34) r = rsIn - b;
        else if (immIn[5:0] == 6'd36) r = rsIn & b;
        else if (immIn[5:0] == 6'd37) r = rsIn | b;
        else if (immIn[5:0] == 6'd42) r = (int'(rsIn) < int'(b)) ? 32'h1 : 32'h0;
        e.wb    = wbIn;
        e.br    = mIn[2];
        e.mr    = mIn[1];
        e.mw    = mIn[0];
        e.zero  = (r == 32'h0);
        e.pcsrc = mIn[2] && (r == 32'h0);
        e.npc   = npcIn + immIn * 4;
        e.alu   = r;
        e.rd2   = rtIn;
        e.dest  = exIn[3] ? rdIdx : rtIdx;
        return e;
    endfunction

    task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                                 input logic [31:0] npc, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] imm, input logic [4:0] rti, input logic [4:0] rdi);
        wbIn = wb; mIn = m; exIn = ex; npcIn = npc;
        rsIn = rs; rtIn = rt; immIn = imm; rtIdx = rti; rdIdx = rdi;
    endtask

    task automatic randomStimulus();
        logic [5:0] functs [6];
        logic [31:0] imm;
        functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'($urandom)};
        imm = $urandom;
        imm[5:0] = functs[$urandom_range(0, 5)];
        applyStimulus(2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom,
                      ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, imm, 5'($urandom), 5'($urandom));
        if ($urandom_range(0, 3) == 0) rtIn = rsIn;
    endtask

    // Advance one edge, updating the model with flush-over-hold priority.
    task automatic stepClock();
        exOut_t nxt;
        if (flush) nxt = '0;
        else if (hold) nxt = expQ;
        else nxt = computeExpected();
        @(posedge clk);
        expQ = nxt;
        #1;
    endtask

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".wb"},     32'(wbOut),    32'(expQ.wb));
        checkField({tag, ".branch"}, 32'(brOut),    32'(expQ.br));
        checkField({tag, ".memrd"},  32'(mrOut),    32'(expQ.mr));
        checkField({tag, ".memwr"},  32'(mwOut),    32'(expQ.mw));
        checkField({tag, ".pcsrc"},  32'(pcsrcOut), 32'(expQ.pcsrc));
        checkField({tag, ".npc"},    npcOut,        expQ.npc);
        checkField({tag, ".zero"},   32'(zeroOut),  32'(expQ.zero));
        checkField({tag, ".alu"},    aluOut,        expQ.alu);
        checkField({tag, ".rd2"},    rd2Out,        expQ.rd2);
        checkField({tag, ".dest"},   32'(destOut),  32'(expQ.dest));
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; expQ = '0;
        applyStimulus(2'b11, 3'b010, 4'b0001, 32'h0, 32'h1000, 32'h7, 32'h10, 5'd4, 5'd8);
        repeat (2) @(posedge clk);
        #1 checkOutput("reset");

        // lw: base + offset, destination from rt field
        rst = 1'b0;
        stepClock();
        checkOutput("lw");
        checkField("lw.alu_const", aluOut, 32'h1010);
        checkField("lw.dest_const", 32'(destOut), 32'd4);

        // async reset between edges
        #2 rst = 1'b1;
        expQ = '0;
        #1 checkOutput("asyncRst");
        @(negedge clk) rst = 1'b0;
        applyStimulus(2'b10, 3'b000, 4'b1100, 32'h40, 32'hFFFFFFFF, 32'h2, 32'h20, 5'd3, 5'd9);
        stepClock();
        checkOutput("addWrap");
        checkField("addWrap.alu_const", aluOut, 32'h1);
        checkField("addWrap.dest_const", 32'(destOut), 32'd9);

        applyStimulus(2'b10, 3'b000, 4'b1100, 32'h0, 32'h80000000, 32'h1, 32'h2A, 5'd1, 5'd2);
        stepClock();
        checkOutput("sltNeg");
        checkField("sltNeg.alu_const", aluOut, 32'h1);
        applyStimulus(2'b10, 3'b000, 4'b1100, 32'h0, 32'h1, 32'h80000000, 32'h2A, 5'd1, 5'd2);
        stepClock();
        checkOutput("sltPos");
        checkField("sltPos.alu_const", aluOut, 32'h0);

        applyStimulus(2'b00, 3'b100, 4'b0010, 32'h100, 32'h55, 32'h55, 32'hFFFFFFFE, 5'd0, 5'd0);
        stepClock();
        checkOutput("beqTaken");
        checkField("beqTaken.npc_const", npcOut, 32'hF8);
        checkField("beqTaken.pcsrc_const", 32'(pcsrcOut), 32'd1);
        rtIn = 32'h56;
        stepClock();
        checkOutput("beqNotTaken");
        checkField("beqNotTaken.pcsrc_const", 32'(pcsrcOut), 32'd0);

        // hold with changing inputs, then flush+hold together
        applyStimulus(2'b11, 3'b010, 4'b0001, 32'h0, 32'h1000, 32'h7, 32'h10, 5'd4, 5'd8);
        stepClock();
        checkOutput("preHold");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomStimulus();
            stepClock();
            checkOutput("hold");
        end
        flush = 1'b1;
        stepClock();
        checkOutput("flushHold");
        checkField("flushHold.alu_const", aluOut, 32'h0);
        hold = 1'b0; flush = 1'b0;

        for (int i = 0; i < 300; i++) begin
            randomStimulus();
            hold  = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stepClock();
            checkOutput("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i_execute.md
# i_execute

MIPS execute stage, directly downstream of the decode stage. Consumes the ID/EX pipeline values and performs:
- ALU control decode;
- the 32-bit ALU operation;
- branch target computation;
- destination-register selection.

It owns the EX/MEM pipeline register. Its `EX_MEM_PCSrc` and `EX_MEM_NPC` outputs feed back to the fetch stage for branch redirection.

## Interface
Parameters
- none (datapath fixed at 32 bits, register index at 5 bits)

Ports (one clock; reset asynchronous, active-high)
- `clk`  in  1  stage clock, all registers rising-edge
- `rst`  in  1  asynchronous active-high reset
- `hold`  in  1  EX/MEM register keeps its current contents
- `flush`  in  1  EX/MEM register loads a bubble
- `ID_EX_wb_ctlout`  in  2  {regwrite, memtoreg}
- `ID_EX_m_ctlout`  in  3  {branch, memread, memwrite}
- `ID_EX_ex_ctlout`  in  4  {regdst, aluop[1:0], alusrc}
- `ID_EX_npcout`  in  32  PC+4 of the instruction
- `ID_EX_rdata1out`  in  32  rs operand
- `ID_EX_rdata2out`  in  32  rt operand
- `ID_EX_s_extendout`  in  32  sign-extended immediate; bits [5:0] are funct
- `ID_EX_instrout_2016`  in  5  rt index
- `ID_EX_instrout_1511`  in  5  rd index
- `EX_MEM_wb_ctlout`  out  2  registered WB controls
- `EX_MEM_branch`, `EX_MEM_memread`, `EX_MEM_memwrite`  out  1 each  registered M controls
- `EX_MEM_PCSrc`  out  1  registered branch-taken (branch & zero)
- `EX_MEM_NPC`  out  32  registered branch target
- `EX_MEM_zero`  out  1  registered ALU-result-is-zero
- `EX_MEM_alu_result`  out  32  registered ALU result
- `EX_MEM_rdata2out`  out  32  registered rt operand (store data)
- `EX_MEM_five_bit_muxout`  out  5  registered destination register

## Operation
- **Operand B:**
  - `alusrc`=1 → `ID_EX_s_extendout`;
  - `alusrc`=0 → `ID_EX_rdata2out`.
- **ALU control from `aluop`:**
  - 00 → add;
  - 01 → sub;
  - 11 → add;
  - 10 → decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct → result 32'h0.
- **Arithmetic:**
  - add/sub wrap modulo 2^32; no overflow detection or trap.
  - slt is signed two's-complement and yields 32'h1 or 32'h0.
- **zero** = (ALU result == 0), computed on the 32-bit result.
- **Branch target** = `ID_EX_npcout` + (`ID_EX_s_extendout` << 2), modulo 2^32.
- **Destination:**
  - `regdst`=1 → `ID_EX_instrout_1511`;
  - `regdst`=0 → `ID_EX_instrout_2016`.
- **PCSrc** = `branch` AND `zero`, registered with the rest.
- **EX/MEM register update, priority order:**
  1. `rst` → all outputs 0, asynchronously.
  2. `flush` → bubble: all control outputs (wb, branch, memread, memwrite, PCSrc) 0; all data outputs 0.
  3. `hold` → every output retains its value.
  4. Otherwise → load the computed values.
- **Simultaneous `flush` and `hold`:** flush wins.

## Timing
- Combinational path ID/EX inputs → EX/MEM D inputs; registered outputs update one cycle after inputs are presented (latency 1).
- Reset:
  - asserting `rst` clears every output immediately, without waiting for a clock edge;
  - deassertion takes effect at the first rising edge where `rst` is low;
  - reset mid-instruction discards that instruction.
- `hold` and `flush` are sampled at the rising edge only; glitches between edges have no effect.
- A taken branch presents `EX_MEM_PCSrc`=1 for exactly one cycle, unless `hold` is asserted, in which case it persists for the hold duration.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs 0 before the next edge; release → next edge loads inputs.
- **R-type add, overflow wrap:** `aluop`=10, funct=100000, rs=32'hFFFFFFFF, rt=32'h2, `regdst`=1, rd=5'd9 → next edge: `alu_result`=32'h1, zero=0, `five_bit_muxout`=9.
- **slt signed:** funct=101010, rs=32'h80000000, rt=32'h1 → result 32'h1; swap operands → 32'h0.
- **beq taken:** `aluop`=01, rs=rt=32'h55, branch=1, npc=32'h100, imm=32'hFFFFFFFE → PCSrc=1, zero=1, NPC=32'hF8; with rt=32'h56 → PCSrc=0.
- **lw path:** `aluop`=00, `alusrc`=1, rs=32'h1000, imm=32'h10, `regdst`=0, rt index 5'd4, wb=2'b11, memread=1 → result 32'h1010, dest 4, memread=1.
- **hold/flush:** load an instruction, then assert `hold` 3 cycles with changing inputs → outputs constant; then assert `hold`+`flush` together → all outputs 0 next edge.
